fu_branch_q: RTL
================

# fu_branch_q

Parametrised branch functional unit with a small result queue and back-pressure. It resolves the full RV32I conditional-branch set plus JAL/JALR against a per-instruction taken prediction and computes link data and redirect targets. Results are held in an OUT_DEPTH-entry queue toward the ROB/CDB arbiter. It sits between the branch reservation station/PRF read and the ROB. Queued results younger than an incoming mispredict are squashed in place.

## Interface
- XLEN, 32, datapath width
- PREG_W, 7, physical register index width
- ROB_W, 5, ROB tag width; ROB has 2^ROB_W entries
- OUT_DEPTH, 2, result queue entries (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issued  in  1  RS issues an instruction this cycle
- fu_ready  out  1  queue can accept; (count < OUT_DEPTH)
- opcode  in  7; func3  in  3; pc  in  XLEN; imm  in  XLEN (sign-extended)
- pd  in  PREG_W  destination preg; rob_index  in  ROB_W  tag; pred_taken  in  1  fetch prediction
- ps1_data, ps2_data  in  XLEN  operands
- curr_rob_tag  in  ROB_W  ROB tail (next free tag)
- mispredict_in  in  1; mispredict_tag_in  in  ROB_W  external flush from an older branch
- out_valid  out  1; out_ready  in  1  result handshake
- out_rob_tag  out  ROB_W; out_pd  out  PREG_W; out_data  out  XLEN (link = pc+4)
- out_writes_rd  out  1; out_target  out  XLEN; out_mispredict  out  1; out_mispredict_tag  out  ROB_W

## Operation
- Decode: opcode 1100011, func3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU (signed compares for 100/101). Opcode 1101111 → JAL. Opcode 1100111 with func3 000 → JALR.
- Conditional branch: taken → target = pc+imm; not taken → target = pc+4. mispredict = taken ≠ pred_taken. writes_rd = 0.
- JAL: target = pc+imm; data = pc+4; writes_rd = 1; mispredict = !pred_taken.
- JALR: target = (ps1+imm) & ~1; data = pc+4; writes_rd = 1; mispredict = 1 always.
- Any other opcode/func3 pair: the entry is enqueued with writes_rd = 0, mispredict = 0, target = pc+4.
- All sums are modulo 2^XLEN. mispredict_tag equals the entry's own rob_index.
- Push on issued && fu_ready. An issued pulse while fu_ready = 0 is ignored.
- Queue: circular, OUT_DEPTH entries, each with a live bit. Pop when the head is live and out_valid && out_ready. Pop silently, one per cycle, when the head is dead. out_* fields reflect the head entry.
- Age test: younger(t) = ((t − m) mod 2^ROB_W) ≠ 0 and < ((curr_rob_tag − m) mod 2^ROB_W), where m = mispredict_tag_in. The flushing tag itself is never younger.
- Flush: when mispredict_in is high, every live entry with younger(rob_index) is cleared to dead, and so is an instruction being pushed that cycle.
- out_valid = head live && !(mispredict_in && younger(head tag)). The squash is combinational on the same cycle.
- A dead entry drives all out_* fields to 0.

## Timing
- Reset values: fu_ready = 1, out_valid = 0, all out_* = 0, count = 0, pointers = 0.
- Latency: an issue at edge N into an empty queue gives out_valid high after edge N (1 cycle).
- Full queue: fu_ready = 0. A same-cycle pop does not reopen fu_ready until the next cycle (no bypass).
- Simultaneous push, pop and flush: the flush is evaluated first on both the stored entries and the incoming entry, then the pop, then the push.
- Pointer wrap-around at OUT_DEPTH−1 → 0. The ROB tag age compare wraps at 2^ROB_W.
- Reset mid-operation clears all entries on the next edge; results in flight are lost.

## Configuration
- BRANCH_STATS_EN defined: adds outputs stat_branches (out, 32) and stat_mispredicts (out, 32).
  - They count live pops of conditional branches and of entries with out_mispredict = 1.
  - Both saturate at 2^32−1 and are cleared by reset.
- Undefined: the stat ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset: 1 cycle reset → fu_ready = 1, out_valid = 0, all out_* = 0.
- JALR: pc = 1000, imm = 20, ps1 = 501, pd = 5, rob_index = 2, out_ready = 1 → next cycle out_target = 520, out_data = 1004, out_writes_rd = 1, out_mispredict = 1, out_rob_tag = 2.
- BLT signed: ps1 = 0xFFFFFFFF, ps2 = 1, pc = 2000, imm = 100, pred_taken = 0, tag 12 → out_target = 2100, mispredict = 1, mispredict_tag = 12. The same operands as BLTU → not taken, target 2004, mispredict = 0.
- Back-pressure: OUT_DEPTH = 2, out_ready = 0, two issues (tags 4, 5) → fu_ready = 0. Raise out_ready → tag 4 then tag 5 popped in order. fu_ready returns to 1 the cycle after the first pop.
- Flush with wrap: queue holds tags 30, 1, 3. Apply mispredict_tag_in = 31 with curr_rob_tag = 2 → tag 1 is squashed, tags 30 and 3 survive. The dead entry is skipped without out_valid.
- Same-cycle squash of head: head tag 3 valid, mispredict_in = 1 with tag 1 and tail 5 → out_valid drops that cycle. The entry is never handshaken.

Source files
------------

// File: rtl/fu_branch_q.sv
// fu_branch_q: branch functional unit with a small result queue.
// Resolves RV32I conditional branches plus JAL/JALR against the fetch
// prediction. Results wait in an OUT_DEPTH-entry circular queue for the
// ROB/CDB arbiter. Queued results younger than an external mispredict are
// squashed in place and later dropped from the head without a handshake.
// Optional feature macro: BRANCH_STATS_EN adds saturating counters of
// retired conditional branches and mispredicts (stat_branches, stat_mispredicts).
module fu_branch_q #(
    parameter int XLEN      = 32,
    parameter int PREG_W    = 7,
    parameter int ROB_W     = 5,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issued,
    output logic              fu_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [PREG_W-1:0] pd,
    input  logic [ROB_W-1:0]  rob_index,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic [ROB_W-1:0]  curr_rob_tag,
    input  logic              mispredict_in,
    input  logic [ROB_W-1:0]  mispredict_tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROB_W-1:0]  out_rob_tag,
    output logic [PREG_W-1:0] out_pd,
    output logic [XLEN-1:0]   out_data,
    output logic              out_writes_rd,
    output logic [XLEN-1:0]   out_target,
    output logic              out_mispredict,
    output logic [ROB_W-1:0]  out_mispredict_tag
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);

    // Tag t is younger than the flushing tag m when it lies strictly between
    // m and the ROB tail, measured modulo the ROB size.
    function automatic logic younger(input logic [ROB_W-1:0] t,
                                     input logic [ROB_W-1:0] m,
                                     input logic [ROB_W-1:0] tail);
        logic [ROB_W-1:0] dt;
        logic [ROB_W-1:0] dc;
        dt = t - m;
        dc = tail - m;
        return (dt != '0) && (dt < dc);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Queue storage: live bits and pointers are control, payload is data.
    logic [OUT_DEPTH-1:0] live;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic [ROB_W-1:0]  tag_q    [OUT_DEPTH];
    logic [PREG_W-1:0] pd_q     [OUT_DEPTH];
    logic [XLEN-1:0]   data_q   [OUT_DEPTH];
    logic [XLEN-1:0]   target_q [OUT_DEPTH];
    logic              wr_q     [OUT_DEPTH];
    logic              misp_q   [OUT_DEPTH];

    // Resolution of the incoming instruction.
    logic signed [XLEN-1:0] s1;
    logic signed [XLEN-1:0] s2;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_data;
    logic            res_wr;
    logic            res_misp;
    logic            taken;
    logic            push;
    logic            pop;
    logic            head_live;

    assign s1       = ps1_data;
    assign s2       = ps2_data;
    assign link     = pc + XLEN'(4);
    assign jalr_sum = ps1_data + imm;

    // Decode the instruction and resolve direction, target, link and mispredict.
    always_comb begin
        res_target = link;
        res_data   = '0;
        res_wr     = 1'b0;
        res_misp   = 1'b0;
        taken      = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (func3)
                    3'b000:  taken = (ps1_data == ps2_data);
                    3'b001:  taken = (ps1_data != ps2_data);
                    3'b100:  taken = (s1 < s2);
                    3'b101:  taken = (s1 >= s2);
                    3'b110:  taken = (ps1_data < ps2_data);
                    3'b111:  taken = (ps1_data >= ps2_data);
                    default: taken = 1'b0;
                endcase
                if (func3 != 3'b010 && func3 != 3'b011) begin
                    res_target = taken ? (pc + imm) : link;
                    res_misp   = (taken != pred_taken);
                end
            end
            OP_JAL: begin
                res_target = pc + imm;
                res_data   = link;
                res_wr     = 1'b1;
                res_misp   = !pred_taken;
            end
            OP_JALR: begin
                if (func3 == 3'b000) begin
                    res_target = {jalr_sum[XLEN-1:1], 1'b0};
                    res_data   = link;
                    res_wr     = 1'b1;
                    res_misp   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign fu_ready  = (count < DEPTH_C);
    assign push      = issued && fu_ready;
    assign head_live = live[head];
    assign out_valid = head_live &&
                       !(mispredict_in && younger(tag_q[head], mispredict_tag_in, curr_rob_tag));
    // Occupied head leaves on a handshake, or silently once it is dead.
    assign pop       = (count != '0) && (!head_live || (out_valid && out_ready));

    assign out_rob_tag        = out_valid ? tag_q[head]    : '0;
    assign out_pd             = out_valid ? pd_q[head]     : '0;
    assign out_data           = out_valid ? data_q[head]   : '0;
    assign out_writes_rd      = out_valid ? wr_q[head]     : 1'b0;
    assign out_target         = out_valid ? target_q[head] : '0;
    assign out_mispredict     = out_valid ? misp_q[head]   : 1'b0;
    assign out_mispredict_tag = out_valid ? tag_q[head]    : '0;

    // Queue control: flush first, then pop, then push; count tracks occupied slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                if (mispredict_in && younger(tag_q[i], mispredict_tag_in, curr_rob_tag))
                    live[i] <= 1'b0;
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= ptr_next(head);
            end
            if (push) begin
                live[tail] <= !(mispredict_in && younger(rob_index, mispredict_tag_in, curr_rob_tag));
                tail       <= ptr_next(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload capture at the tail slot on push.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail]    <= rob_index;
            pd_q[tail]     <= pd;
            data_q[tail]   <= res_data;
            target_q[tail] <= res_target;
            wr_q[tail]     <= res_wr;
            misp_q[tail]   <= res_misp;
        end
    end

`ifdef BRANCH_STATS_EN
    logic cond_q [OUT_DEPTH];
    logic push_cond;
    logic live_pop;

    assign push_cond = (opcode == OP_BRANCH) && (func3 != 3'b010) && (func3 != 3'b011);
    assign live_pop  = out_valid && out_ready;

    // Remember which entries are conditional branches.
    always_ff @(posedge clk) begin
        if (push)
            cond_q[tail] <= push_cond;
    end

    // Saturating counters of handshaken branches and mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (live_pop) begin
            if (cond_q[head] && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (misp_q[head] && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
